kyber_stream_if: RTL and testbench
==================================

Name: kyber_stream_if

Overview:
- Host-side streaming front end for the Kyber KEM core (CCA top).
- Assembles the wide operand buses (random_coin, m, pk, sk, c) from 32-bit addressed word writes, and accepts a command.
- Pulses the core's start, waits for finish, then streams the mode-dependent results back out as a 32-bit valid/ready stream.
- Sits directly upstream and downstream of the Kyber top and is its only driver.

Parameters:
- WORD_W, 32, host word width; fixed; all word counts below assume 32.
- ADDR_W, 9, word address width; covers the largest buffer (sk, 408 words).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  host word-write valid.
- in_ready  out  1  high only in IDLE.
- in_sel  in  3  target buffer: 0 random_coin (8 words), 1 m (8), 2 pk (200), 3 sk (408), 4 c (192); 5-7 invalid.
- in_addr  in  ADDR_W  word index in the target buffer.
- in_data  in  WORD_W  word data.
- cmd_valid  in  1  operation request.
- cmd_ready  out  1  high only in IDLE.
- cmd_kyber_mode  in  2  security level, passed to the core.
- cmd_mode  in  2  0 keygen, 1 encaps, 2 decaps, 3 reserved.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky; set on a dropped write or a reserved mode; cleared only by reset.
- top_start  out  1  one-cycle start pulse to the core.
- top_kyber_mode, top_mode  out  2 each  latched command fields.
- top_random_coin  out  256  assembled buffer.
- top_m_in  out  256  assembled buffer.
- top_pk_in  out  6400  assembled buffer.
- top_sk_in  out  13056  assembled buffer.
- top_c_in  out  6144  assembled buffer.
- top_finish  in  1  core done.
- top_pk_out  in  6400  core result.
- top_sk_out  in  13056  core result.
- top_c_out  in  6144  core result.
- top_K_out  in  256  core result.
- out_valid  out  1  result word valid.
- out_ready  in  1  host accepts the result word.
- out_data  out  WORD_W  result word.
- out_last  out  1  marks the final word of the result.

Behaviour:
- Word packing: word i of a buffer occupies bits [32i+31:32i]; word 0 is the least significant.
- Reset (rst=0 at an edge), whether idle or mid-operation:
  - State returns to IDLE.
  - All input buffers, the latched mode fields and err clear to 0.
  - top_start=0, out_valid=0, out_last=0, out_data=0.
  - Any in-flight core run is abandoned; a later top_finish is ignored outside WAIT.
- States: IDLE, START, WAIT, DRAIN.
- IDLE:
  - in_ready=cmd_ready=1.
  - A write fires when in_valid=1 and in_sel/in_addr are in range; the word is written at that edge.
  - An out-of-range write (invalid in_sel, or in_addr ≥ word count) is accepted, dropped, and sets err.
  - A command is accepted on cmd_valid=1.
  - If cmd_mode=3: err is set and the state stays IDLE.
  - Otherwise: the mode fields are latched and the state goes to START.
  - A write and a command in the same cycle: both take effect; the write is visible to the core.
- START:
  - top_start=1 for exactly this one cycle, then go to WAIT.
  - Input buffers are frozen from command accept until the return to IDLE.
- WAIT:
  - On top_finish=1, go to DRAIN with the word pointer at 0.
  - The first out_valid is asserted the cycle after top_finish is sampled.
  - No timeout.
- DRAIN:
  - Output sequence per mode:
    - keygen: pk words 0..199, then sk words 0..407 (608 words).
    - encaps: c words 0..191, then K words 0..7 (200 words).
    - decaps: K words 0..7.
  - top_* results are sampled live; the core holds them stable until the next top_start.
  - out_data and out_last are registered.
  - out_valid stays high, with data stable, until out_ready=1.
  - On a handshake, the next word is presented the next cycle, so one word per cycle is sustainable with out_ready held high.
  - out_last=1 only on the final word.
  - The handshake on the last word returns the state to IDLE, with out_valid=0 the next cycle.
- top_finish outside WAIT is ignored. A repeated top_finish in DRAIN has no effect.
- Input buffers persist across commands; a new command reuses any words not rewritten.

Test Plan:
- Reset: hold rst=0 for 2 cycles → all outputs 0, in_ready=1, busy=0, err=0.
- Load: write sel=3, addr=407, data=0xDEADBEEF → top_sk_in[13055:13024]=0xDEADBEEF, all other bits 0; write sel=3, addr=408 → dropped, err=1.
- Encaps: cmd mode=1, kyber_mode=2; model top_finish 20 cycles after top_start, c_out word k = k, K_out word k = 0x100+k; out_ready=1 → top_start high exactly 1 cycle; 200 words 0..191 then 0x100..0x107; out_last only on 0x107; then IDLE.
- Backpressure: decaps with out_ready toggling 1,0,0,1… → each word held stable while stalled; exactly 8 words, none duplicated or skipped.
- Reserved mode plus same-cycle write: cmd mode=3 with a valid write → write lands, err=1, no top_start, stays IDLE.
- Mid-run reset: rst=0 during WAIT, then top_finish pulses → no out_valid, buffers 0, IDLE.

Source files
------------

// File: rtl/kyber_stream_if.sv
// rtl/kyber_stream_if.sv - Host streaming front end for the Kyber KEM core
// Packs 32-bit host writes into the core's operand buses and streams results back out.
module kyber_stream_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_sel,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [WORD_W-1:0] in_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kyber_mode,
  input  logic [1:0]        cmd_mode,
  output logic              busy,
  output logic              err,
  output logic              top_start,
  output logic [1:0]        top_kyber_mode,
  output logic [1:0]        top_mode,
  output logic [255:0]      top_random_coin,
  output logic [255:0]      top_m_in,
  output logic [6399:0]     top_pk_in,
  output logic [13055:0]    top_sk_in,
  output logic [6143:0]     top_c_in,
  input  logic              top_finish,
  input  logic [6399:0]     top_pk_out,
  input  logic [13055:0]    top_sk_out,
  input  logic [6143:0]     top_c_out,
  input  logic [255:0]      top_K_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DRAIN} state_t;

  state_t              r_state, w_next;
  logic [255:0]        r_coin, r_m;
  logic [6399:0]       r_pk;
  logic [13055:0]      r_sk;
  logic [6143:0]       r_c;
  logic [1:0]          r_kmode, r_mode;
  logic                r_err, r_out_last;
  logic [WORD_W-1:0]   r_out_data;
  logic [9:0]          r_ptr;

  logic                w_idle, w_in_range, w_wr, w_wr_drop, w_cmd_ok, w_cmd_bad;
  logic                w_hs, w_load;
  logic [9:0]          w_fidx, w_last_idx;
  logic [8:0]          w_sk_idx;
  logic [2:0]          w_k_idx;
  logic [WORD_W-1:0]   w_word;

  assign w_idle    = (r_state == S_IDLE);
  assign w_wr      = w_idle && in_valid && w_in_range;
  assign w_wr_drop = w_idle && in_valid && !w_in_range;
  assign w_cmd_ok  = w_idle && cmd_valid && (cmd_mode != 2'd3);
  assign w_cmd_bad = w_idle && cmd_valid && (cmd_mode == 2'd3);
  assign w_hs      = (r_state == S_DRAIN) && out_ready;
  assign w_load    = ((r_state == S_WAIT) && top_finish) || (w_hs && !r_out_last);
  assign w_fidx    = (r_state == S_WAIT) ? 10'd0 : r_ptr + 10'd1;
  assign w_sk_idx  = 9'(w_fidx - 10'd200);
  assign w_k_idx   = (r_mode == 2'd1) ? 3'(w_fidx - 10'd192) : w_fidx[2:0];

  always_comb begin
    w_in_range = 1'b0;
    case (in_sel)
      3'd0, 3'd1: w_in_range = (in_addr < ADDR_W'(8));
      3'd2:       w_in_range = (in_addr < ADDR_W'(200));
      3'd3:       w_in_range = (in_addr < ADDR_W'(408));
      3'd4:       w_in_range = (in_addr < ADDR_W'(192));
      default:    w_in_range = 1'b0;
    endcase
  end

  // Result word for the fetch index; the core holds its outputs stable while we drain.
  always_comb begin
    w_word     = '0;
    w_last_idx = 10'd7;
    case (r_mode)
      2'd0: begin
        w_last_idx = 10'd607;
        if (w_fidx < 10'd200) w_word = top_pk_out[{w_fidx[7:0], 5'b0} +: WORD_W];
        else                  w_word = top_sk_out[{w_sk_idx, 5'b0} +: WORD_W];
      end
      2'd1: begin
        w_last_idx = 10'd199;
        if (w_fidx < 10'd192) w_word = top_c_out[{w_fidx[7:0], 5'b0} +: WORD_W];
        else                  w_word = top_K_out[{w_k_idx, 5'b0} +: WORD_W];
      end
      default: begin
        w_last_idx = 10'd7;
        w_word     = top_K_out[{w_k_idx, 5'b0} +: WORD_W];
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_ok) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (top_finish) w_next = S_DRAIN;
      S_DRAIN: if (w_hs && r_out_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_coin     <= '0;
      r_m        <= '0;
      r_pk       <= '0;
      r_sk       <= '0;
      r_c        <= '0;
      r_kmode    <= '0;
      r_mode     <= '0;
      r_err      <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
      r_ptr      <= '0;
    end else begin
      if (w_wr) begin
        case (in_sel)
          3'd0:    r_coin[{in_addr[2:0], 5'b0} +: WORD_W] <= in_data;
          3'd1:    r_m[{in_addr[2:0], 5'b0} +: WORD_W]    <= in_data;
          3'd2:    r_pk[{in_addr[7:0], 5'b0} +: WORD_W]   <= in_data;
          3'd3:    r_sk[{in_addr, 5'b0} +: WORD_W]        <= in_data;
          default: r_c[{in_addr[7:0], 5'b0} +: WORD_W]    <= in_data;
        endcase
      end
      if (w_wr_drop || w_cmd_bad) r_err <= 1'b1;
      if (w_cmd_ok) begin
        r_kmode <= cmd_kyber_mode;
        r_mode  <= cmd_mode;
      end
      if (w_load) begin
        r_out_data <= w_word;
        r_out_last <= (w_fidx == w_last_idx);
        r_ptr      <= w_fidx;
      end else if (w_hs) begin
        r_out_last <= 1'b0;
      end
    end
  end

  assign in_ready        = w_idle;
  assign cmd_ready       = w_idle;
  assign busy            = !w_idle;
  assign err             = r_err;
  assign top_start       = (r_state == S_START);
  assign top_kyber_mode  = r_kmode;
  assign top_mode        = r_mode;
  assign top_random_coin = r_coin;
  assign top_m_in        = r_m;
  assign top_pk_in       = r_pk;
  assign top_sk_in       = r_sk;
  assign top_c_in        = r_c;
  assign out_valid       = (r_state == S_DRAIN);
  assign out_data        = r_out_data;
  assign out_last        = r_out_last;

endmodule

// File: tb/tb_kyber_stream_if.sv
// tb/tb_kyber_stream_if.sv - Self-checking bench for kyber_stream_if
// Word-array model of the host buffers and core results; expected streams built per mode.
module tb_kyber_stream_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, cmd_valid, cmd_ready, busy, err, top_start;
  logic [2:0]    in_sel;
  logic [8:0]    in_addr;
  logic [31:0]   in_data, out_data;
  logic [1:0]    cmd_kyber_mode, cmd_mode, top_kyber_mode, top_mode;
  logic [255:0]  top_random_coin, top_m_in, top_K_out;
  logic [6399:0] top_pk_in, top_pk_out;
  logic [13055:0] top_sk_in, top_sk_out;
  logic [6143:0] top_c_in, top_c_out;
  logic          top_finish, out_valid, out_ready, out_last;

  kyber_stream_if dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_addr(in_addr), .in_data(in_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kyber_mode(cmd_kyber_mode), .cmd_mode(cmd_mode),
    .busy(busy), .err(err), .top_start(top_start), .top_kyber_mode(top_kyber_mode), .top_mode(top_mode),
    .top_random_coin(top_random_coin), .top_m_in(top_m_in), .top_pk_in(top_pk_in),
    .top_sk_in(top_sk_in), .top_c_in(top_c_in), .top_finish(top_finish),
    .top_pk_out(top_pk_out), .top_sk_out(top_sk_out), .top_c_out(top_c_out), .top_K_out(top_K_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_coin[8], m_m[8], m_pk[200], m_sk[408], m_c[192];
  logic [31:0] res_pk[200], res_sk[408], res_c[192], res_k[8];
  logic exp_err;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    foreach (m_coin[i]) m_coin[i] = '0;
    foreach (m_m[i]) m_m[i] = '0;
    foreach (m_pk[i]) m_pk[i] = '0;
    foreach (m_sk[i]) m_sk[i] = '0;
    foreach (m_c[i]) m_c[i] = '0;
    exp_err = 1'b0;
  endtask

  task automatic model_write(input logic [2:0] sel, input int addr, input logic [31:0] data);
    case (sel)
      3'd0: if (addr < 8) m_coin[addr] = data; else exp_err = 1'b1;
      3'd1: if (addr < 8) m_m[addr] = data; else exp_err = 1'b1;
      3'd2: if (addr < 200) m_pk[addr] = data; else exp_err = 1'b1;
      3'd3: if (addr < 408) m_sk[addr] = data; else exp_err = 1'b1;
      3'd4: if (addr < 192) m_c[addr] = data; else exp_err = 1'b1;
      default: exp_err = 1'b1;
    endcase
  endtask

  task automatic host_write(input logic [2:0] sel, input int addr, input logic [31:0] data);
    in_valid = 1'b1; in_sel = sel; in_addr = addr[8:0]; in_data = data;
    tick();
    in_valid = 1'b0;
    model_write(sel, addr, data);
  endtask

  task automatic apply_results();
    foreach (res_pk[i]) top_pk_out[32*i +: 32] = res_pk[i];
    foreach (res_sk[i]) top_sk_out[32*i +: 32] = res_sk[i];
    foreach (res_c[i]) top_c_out[32*i +: 32] = res_c[i];
    foreach (res_k[i]) top_K_out[32*i +: 32] = res_k[i];
  endtask

  task automatic check_bufs(input string tag);
    int bad = 0;
    foreach (m_coin[i]) if (top_random_coin[32*i +: 32] !== m_coin[i]) bad++;
    foreach (m_m[i]) if (top_m_in[32*i +: 32] !== m_m[i]) bad++;
    foreach (m_pk[i]) if (top_pk_in[32*i +: 32] !== m_pk[i]) bad++;
    foreach (m_sk[i]) if (top_sk_in[32*i +: 32] !== m_sk[i]) bad++;
    foreach (m_c[i]) if (top_c_in[32*i +: 32] !== m_c[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_buffers: %0d words differ from model, required 0", tag, bad);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++;
    if ({top_start, out_valid, out_last, in_ready, cmd_ready, busy, err} !== 7'b0001100) begin
      n_fail++;
      $display("FAIL reset_flags: got start/ov/ol/ir/cr/busy/err=%b required 0001100",
               {top_start, out_valid, out_last, in_ready, cmd_ready, busy, err});
    end
    n_checks++;
    if ({out_data, top_mode, top_kyber_mode} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_data_modes: got %h required 0", {out_data, top_mode, top_kyber_mode});
    end
    check_bufs("reset");
  endtask

  task automatic test_load();
    host_write(3'd3, 407, 32'hDEADBEEF);
    n_checks++;
    if (top_sk_in[13055:13024] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_sk407: got %h required deadbeef", top_sk_in[13055:13024]);
    end
    check_bufs("load");
    host_write(3'd3, 408, 32'h12345678);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL load_drop_err: got %b required 1", err);
    end
    check_bufs("load_drop");
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random
  task automatic run_op(input logic [1:0] kmode, input logic [1:0] mode, input int ready_mode,
                        input string tag);
    logic [31:0] exp[$];
    logic [31:0] got[$];
    logic [31:0] held;
    int starts = 0, early_valid = 0, stable_bad = 0, last_bad = 0, data_bad = 0;
    int first_valid = -1, cyc = 0;
    logic stalled = 1'b0, done = 1'b0, ready_blocked = 1'b0;
    case (mode)
      2'd0: begin foreach (res_pk[i]) exp.push_back(res_pk[i]); foreach (res_sk[i]) exp.push_back(res_sk[i]); end
      2'd1: begin foreach (res_c[i]) exp.push_back(res_c[i]); foreach (res_k[i]) exp.push_back(res_k[i]); end
      default: foreach (res_k[i]) exp.push_back(res_k[i]);
    endcase
    cmd_valid = 1'b1; cmd_kyber_mode = kmode; cmd_mode = mode;
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if ({busy, top_kyber_mode, top_mode} !== {1'b1, kmode, mode}) begin
      n_fail++;
      $display("FAIL %s_accept: got busy/kmode/mode=%b required %b", tag,
               {busy, top_kyber_mode, top_mode}, {1'b1, kmode, mode});
    end
    for (int i = 0; i < 20; i++) begin
      if (top_start) starts++;
      if (out_valid) early_valid++;
      if (i == 5) begin
        ready_blocked = !in_ready;
        in_valid = 1'b1; in_sel = 3'd0; in_addr = 9'd0; in_data = ~m_coin[0];
      end
      tick();
      in_valid = 1'b0;
    end
    n_checks++;
    if (starts != 1 || early_valid != 0 || !ready_blocked) begin
      n_fail++;
      $display("FAIL %s_start: got starts=%0d early_valid=%0d in_ready_low=%b required 1 0 1",
               tag, starts, early_valid, ready_blocked);
    end
    top_finish = 1'b1;
    tick();
    top_finish = 1'b0;
    while (!done && cyc < 5000) begin
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      top_finish = (cyc == 3);
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled && out_data !== held) stable_bad++;
        if (out_ready) begin
          got.push_back(out_data);
          if (out_last !== (got.size() == exp.size())) last_bad++;
          stalled = 1'b0;
          if (out_last) done = 1'b1;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    top_finish = 1'b0;
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) data_bad++;
    n_checks++;
    if (!done || got.size() != exp.size() || first_valid != 0) begin
      n_fail++;
      $display("FAIL %s_count: got done=%b words=%0d first_valid_cycle=%0d required 1 %0d 0",
               tag, done, got.size(), first_valid, exp.size());
    end
    n_checks++;
    if (data_bad != 0) begin
      n_fail++;
      $display("FAIL %s_data: %0d words differ from model, required 0", tag, data_bad);
    end
    n_checks++;
    if (last_bad != 0 || stable_bad != 0) begin
      n_fail++;
      $display("FAIL %s_last_stable: got last_errs=%0d unstable=%0d required 0 0", tag, last_bad, stable_bad);
    end
    n_checks++;
    if ({out_valid, busy, err} !== {2'b00, exp_err}) begin
      n_fail++;
      $display("FAIL %s_end: got valid/busy/err=%b required 00%b", tag, {out_valid, busy, err}, exp_err);
    end
    check_bufs(tag);
  endtask

  task automatic test_encaps();
    foreach (res_c[k]) res_c[k] = k;
    foreach (res_k[k]) res_k[k] = 32'h100 + k;
    foreach (res_pk[k]) res_pk[k] = $urandom;
    foreach (res_sk[k]) res_sk[k] = $urandom;
    apply_results();
    run_op(2'd2, 2'd1, 0, "encaps");
  endtask

  task automatic test_backpressure();
    foreach (res_k[k]) res_k[k] = $urandom;
    apply_results();
    run_op(2'd1, 2'd2, 1, "decaps_bp");
  endtask

  task automatic test_keygen_random();
    for (int i = 0; i < 12; i++)
      host_write(3'($urandom_range(0, 5)), $urandom_range(0, 420), $urandom);
    foreach (res_pk[k]) res_pk[k] = $urandom;
    foreach (res_sk[k]) res_sk[k] = $urandom;
    apply_results();
    run_op(2'($urandom_range(0, 3)), 2'd0, 2, "keygen");
  endtask

  task automatic test_reserved_mode();
    int starts = 0, busy_seen = 0;
    do_reset(1);
    in_valid = 1'b1; in_sel = 3'd1; in_addr = 9'd3; in_data = 32'hA5A5_0033;
    cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_kyber_mode = 2'd1;
    tick();
    in_valid = 1'b0; cmd_valid = 1'b0;
    model_write(3'd1, 3, 32'hA5A5_0033);
    exp_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (top_start) starts++;
      if (busy) busy_seen++;
      tick();
    end
    n_checks++;
    if ({err, starts == 0, busy_seen == 0, in_ready} !== 4'b1111) begin
      n_fail++;
      $display("FAIL reserved: got err=%b starts=%0d busy_cycles=%0d in_ready=%b required 1 0 0 1",
               err, starts, busy_seen, in_ready);
    end
    check_bufs("reserved");
  endtask

  task automatic test_midrun_reset();
    int valid_seen = 0, busy_seen = 0;
    host_write(3'd2, 5, 32'h0BAD_F00D);
    host_write(3'd4, 191, 32'h7777_1111);
    cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_kyber_mode = 2'd3;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: got %b required 1", busy);
    end
    do_reset(1);
    top_finish = 1'b1;
    tick();
    top_finish = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) valid_seen++;
      if (busy) busy_seen++;
      tick();
    end
    n_checks++;
    if (valid_seen != 0 || busy_seen != 0 || {err, top_mode, top_kyber_mode} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got valid=%0d busy=%0d err/modes=%b required 0 0 00000",
               valid_seen, busy_seen, {err, top_mode, top_kyber_mode});
    end
    check_bufs("midrun");
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sel = '0; in_addr = '0; in_data = '0;
    cmd_valid = 1'b0; cmd_kyber_mode = '0; cmd_mode = '0;
    top_finish = 1'b0; out_ready = 1'b0;
    top_pk_out = '0; top_sk_out = '0; top_c_out = '0; top_K_out = '0;
    clear_model();
    test_reset();
    test_load();
    test_encaps();
    test_backpressure();
    test_keygen_random();
    test_reserved_mode();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
